tcam_rule_writer: RTL and testbench
===================================

// Module: tcam_rule_writer
// PURPOSE
// - Write path of the SRAM-based TCAM; the opposite direction of the match-side priority encoder.
// - Takes one ternary rule (data, mask) and a target entry address, decodes the address to a one-hot column
//   bit-enable, and sweeps every row of every SRAM sub-block, so that later lookups assert MA[addr] exactly
//   for keys the rule covers.
// PARAMETERS
// - K  256  number of TCAM entries (SRAM columns); power of 2, >= 2
// - W  32   rule/key width in bits
// - N  8    key bits per SRAM sub-block (2^N rows per sub-block); W % N == 0 is required
// - P  W/N  derived (localparam): number of sub-blocks
// PORTS
// - clk          in   1          single clock, rising edge
// - rst          in   1          asynchronous reset, active-high
// - req_valid    in   1          rule write/delete request valid
// - req_ready    out  1          writer idle, request accepted when req_valid & req_ready
// - req_addr     in   $clog2(K)  target entry index
// - req_data     in   W          rule value
// - req_mask     in   W          1 = don't-care bit
// - req_del      in   1          1 = delete entry (column cleared in every row)
// - sram_we      out  1          SRAM row write strobe
// - sram_blk     out  max(1,$clog2(P))  sub-block index
// - sram_row     out  N          row index inside sub-block
// - sram_bwe     out  [0:K-1]    one-hot column bit-enable, bit index == req_addr (MSB-first like MA)
// - sram_wbit    out  1          value written into the enabled column
// - done         out  1          one-cycle pulse after last row write
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE; req_ready=1; sram_we=0, sram_blk=0, sram_row=0,
//   sram_bwe=0, sram_wbit=0, done=0; latched request cleared.
// - FSM IDLE -> WRITE on accept; WRITE -> DONE after row 2^N-1 of block P-1; DONE -> IDLE unconditionally.
// - req_ready=1 only in IDLE; request fields latched on accept; inputs ignored otherwise.
// - Accept at edge t: write cycles t+1 .. t+P*2^N, one row per cycle, order blk 0..P-1, row 0..2^N-1
//   within each block; done=1 in cycle t+P*2^N+1 (DONE state); req_ready=1 again the cycle after.
// - In WRITE: sram_we=1, sram_bwe=onehot(addr_q) constant for whole operation.
// - sram_wbit = !del_q && (((row ^ data_q[blk]) & ~mask_q[blk]) == 0), where data_q[blk]/mask_q[blk] are
//   bits [blk*N +: N]; non-matching rows are written 0 so any previous rule in the column is erased.
// - Row counter N bits wraps 2^N-1 -> 0 while block counter increments; no counter wraps past block P-1.
// - req_addr >= K (only possible when K not power of 2; disallowed) -> bwe all zero, sweep still runs.
// - Outside WRITE: sram_we=0, sram_bwe=0, sram_wbit=0 (combinationally gated, no X on SRAM pins).
// - rst mid-sweep: immediate abort, outputs to reset values; partially written column is undefined,
//   software must re-issue the write.
// - req_valid during WRITE/DONE: held off (req_ready=0), not dropped by the source.
// STRUCTURE
// - tcam_pkg: state enum (IDLE, WRITE, DONE), shared K/W/N defaults, helper function for block slicing.
// - Sub-module addr_onehot_dec #(K): combinational address -> [0:K-1] one-hot decoder (inverse of LPE);
//   reused by the invalidate path.
// - Top: FSM, row/block counters, request register, wbit compare.
// TESTING (bench with K=16, W=8, N=4, P=2; 32 write cycles per request)
// - Reset: rst pulse mid-idle -> all outputs 0, req_ready=1; asserted async (no clock) outputs clear same time.
// - Exact rule: addr=5, data=8'hA3, mask=0, del=0 -> 32 writes, bwe=16'b0000_0100_0000_0000,
//   wbit=1 only at (blk0,row3) and (blk1,row10); done pulse at accept+33.
// - Ternary: addr=0, data=8'h00, mask=8'h0F -> blk0 all 16 rows wbit=1; blk1 wbit=1 only row0.
// - Delete: addr=15, del=1 -> 32 writes, bwe bit 15 only, wbit=0 every row.
// - Back-to-back: req_valid held high with two requests -> second accepted cycle after done,
//   req_ready=0 for 33 cycles in between, second request fields not corrupted by mid-sweep changes.
// - Abort: rst at write cycle 10 -> sram_we falls async, FSM IDLE, new request then completes normally.

Source files
------------

// File: rtl/tcam_pkg.sv
// Shared definitions for the TCAM rule write path.
// - state_t : writer FSM states (IDLE, WRITE, DONE)
// - TCAM_K/W/N : default entry count, rule width and key bits per sub-block
// - blk_lsb() : LSB position of a sub-block's slice inside a rule/key word
package tcam_pkg;

    localparam int TCAM_K = 256;
    localparam int TCAM_W = 32;
    localparam int TCAM_N = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Sub-block blk covers rule bits [blk*n +: n].
    function automatic int unsigned blk_lsb(input int unsigned blk, input int unsigned n);
        return blk * n;
    endfunction

endpackage

// File: rtl/addr_onehot_dec.sv
// Address to one-hot column decoder (inverse of the match-side priority encoder).
// Ports:
// - addr   in   $clog2(K)  entry index
// - onehot out  [0:K-1]    onehot[addr] = 1, all other bits 0; all zero if addr >= K
// Bit 0 is the leftmost (MSB-first), matching the MA vector ordering.
module addr_onehot_dec #(
    parameter int K = 256,
    localparam int AW = $clog2(K)
) (
    input  logic [AW-1:0] addr,
    output logic [0:K-1]  onehot
);

    for (genvar gi = 0; gi < K; gi++) begin : g_bit
        assign onehot[gi] = (addr == AW'(gi));
    end

endmodule

// File: rtl/tcam_rule_writer.sv
// Write path of the SRAM-based TCAM. Latches one ternary rule (data, mask) or a
// delete for entry req_addr, then sweeps every row of every sub-block, writing
// into the entry's column a 1 for rows the rule covers and 0 for all others.
// Ports:
// - clk, rst              clock, asynchronous active-high reset
// - req_valid/req_ready   request handshake (ready only while idle)
// - req_addr/data/mask/del  request fields (mask bit 1 = don't care)
// - sram_we/blk/row       row write strobe and row address
// - sram_bwe              one-hot column enable [0:K-1], bit req_addr set
// - sram_wbit             bit written into the enabled column
// - done                  one-cycle pulse after the last row write
module tcam_rule_writer
    import tcam_pkg::*;
#(
    parameter int K = TCAM_K,
    parameter int W = TCAM_W,
    parameter int N = TCAM_N,
    localparam int P  = W / N,
    localparam int AW = $clog2(K),
    localparam int BW = (P > 1) ? $clog2(P) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [W-1:0]  req_data,
    input  logic [W-1:0]  req_mask,
    input  logic          req_del,
    output logic          sram_we,
    output logic [BW-1:0] sram_blk,
    output logic [N-1:0]  sram_row,
    output logic [0:K-1]  sram_bwe,
    output logic          sram_wbit,
    output logic          done
);

    state_t        state_reg;
    logic [N-1:0]  row_reg;
    logic [BW-1:0] blk_reg;
    logic [AW-1:0] addr_reg;
    logic [W-1:0]  data_reg;
    logic [W-1:0]  mask_reg;
    logic          del_reg;

    logic [0:K-1]  bwe_dec;
    logic [N-1:0]  data_blk [P];
    logic [N-1:0]  mask_blk [P];
    logic          in_write;
    logic          last_row;
    logic          last_blk;
    logic          row_hit;

    // Per-sub-block views of the latched rule, selected by the block counter.
    for (genvar gi = 0; gi < P; gi++) begin : g_slice
        localparam int unsigned LSB = blk_lsb(gi, N);
        assign data_blk[gi] = data_reg[LSB +: N];
        assign mask_blk[gi] = mask_reg[LSB +: N];
    end

    addr_onehot_dec #(.K(K)) u_dec (
        .addr   (addr_reg),
        .onehot (bwe_dec)
    );

    assign in_write = (state_reg == WRITE);
    assign last_row = &row_reg;
    assign last_blk = (blk_reg == BW'(P - 1));

    // Row is covered when every non-masked bit equals the rule bit.
    assign row_hit = (((row_reg ^ data_blk[blk_reg]) & ~mask_blk[blk_reg]) == '0);

    // SRAM pins are gated by state so nothing leaks out while idle or after reset.
    assign req_ready = (state_reg == IDLE);
    assign done      = (state_reg == DONE);
    assign sram_we   = in_write;
    assign sram_blk  = blk_reg;
    assign sram_row  = row_reg;
    assign sram_bwe  = in_write ? bwe_dec : '0;
    assign sram_wbit = in_write & ~del_reg & row_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            row_reg   <= '0;
            blk_reg   <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            mask_reg  <= '0;
            del_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        addr_reg  <= req_addr;
                        data_reg  <= req_data;
                        mask_reg  <= req_mask;
                        del_reg   <= req_del;
                        state_reg <= WRITE;
                    end
                end
                WRITE: begin
                    // Row counter wraps naturally; block advances on row wrap.
                    row_reg <= row_reg + 1'b1;
                    if (last_row) begin
                        if (last_blk) begin
                            blk_reg   <= '0;
                            state_reg <= DONE;
                        end else begin
                            blk_reg <= blk_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tcam_rule_writer.sv
module tb_tcam_rule_writer;

    localparam int K    = 16;
    localparam int W    = 8;
    localparam int N    = 4;
    localparam int ROWS = 16;
    localparam int NW   = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_addr = '0;
    logic [7:0]  req_data = '0;
    logic [7:0]  req_mask = '0;
    logic        req_del  = 1'b0;
    logic        sram_we;
    logic [0:0]  sram_blk;
    logic [3:0]  sram_row;
    logic [0:K-1] sram_bwe;
    logic        sram_wbit;
    logic        done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [7:0]  data;
        logic [7:0]  mask;
        logic        del;
        logic [15:0] exp_bwe;   // leftmost bit = entry 0
        logic [31:0] exp_wbit;  // bit i = write cycle i (blk*16 + row)
    } vec_t;

    vec_t vecs [12];

    tcam_rule_writer #(.K(K), .W(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_mask  (req_mask),
        .req_del   (req_del),
        .sram_we   (sram_we),
        .sram_blk  (sram_blk),
        .sram_row  (sram_row),
        .sram_bwe  (sram_bwe),
        .sram_wbit (sram_wbit),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a write row is 1 when the key fragment (row) is covered by the
    // rule's bits for that sub-block, i.e. every cared-about bit agrees.
    function automatic logic [31:0] model_wbits(input logic [7:0] d, input logic [7:0] m, input logic del);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < NW; i++) begin
            int  b;
            int  r;
            bit  hit;
            b   = i / ROWS;
            r   = i % ROWS;
            hit = !del;
            for (int j = 0; j < N; j++) begin
                int kb;
                kb = b * N + j;
                if (!m[kb] && (((r >> j) & 1) != int'(d[kb]))) hit = 0;
            end
            v[i] = hit;
        end
        return v;
    endfunction

    function automatic logic [15:0] model_bwe(input logic [3:0] a);
        return 16'h8000 >> a;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", {63'd0, req_ready}, 64'd1);
    endtask

    // Called right after the accepting edge: checks 32 write cycles and the done cycle.
    task automatic sweep(input logic [15:0] eb, input logic [31:0] ew, input bit scramble);
        for (int i = 0; i < NW; i++) begin
            logic [0:0] eblk;
            logic [3:0] erow;
            eblk = 1'(i / ROWS);
            erow = 4'(i % ROWS);
            @(negedge clk);
            chk($sformatf("write%0d", i),
                {40'd0, sram_we, sram_blk, sram_row, sram_bwe, sram_wbit, req_ready, done},
                {40'd0, 1'b1, eblk, erow, eb, ew[i], 1'b0, 1'b0});
            if (scramble) begin
                req_addr = 4'($urandom);
                req_data = 8'($urandom);
                req_mask = 8'($urandom);
                req_del  = 1'($urandom);
            end
        end
        @(negedge clk);
        chk("done_pulse", {44'd0, done, req_ready, sram_we, sram_wbit, sram_bwe},
            {44'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0});
    endtask

    task automatic issue(input vec_t v);
        wait_ready();
        req_addr  = v.addr;
        req_data  = v.data;
        req_mask  = v.mask;
        req_del   = v.del;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        sweep(v.exp_bwe, v.exp_wbit, 1'b1);
        @(negedge clk);
        chk("ready_back", {62'd0, req_ready, done}, 64'd2);
        $display("txn addr=%0d data=%h mask=%h del=%0d", v.addr, v.data, v.mask, v.del);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {36'd0, req_ready, sram_we, sram_blk, sram_row, sram_bwe, sram_wbit, done},
            {36'd0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0});
    endtask

    initial begin
        // Directed entries with hand-derived expectations.
        vecs[0] = '{addr: 4'd5,  data: 8'hA3, mask: 8'h00, del: 1'b0, exp_bwe: 16'b0000_0100_0000_0000, exp_wbit: 32'h0400_0008};
        vecs[1] = '{addr: 4'd0,  data: 8'h00, mask: 8'h0F, del: 1'b0, exp_bwe: 16'h8000, exp_wbit: 32'h0001_FFFF};
        vecs[2] = '{addr: 4'd15, data: 8'h5C, mask: 8'h30, del: 1'b1, exp_bwe: 16'h0001, exp_wbit: 32'h0000_0000};
        for (int i = 3; i < 12; i++) begin
            vecs[i].addr     = 4'($urandom_range(0, 15));
            vecs[i].data     = 8'($urandom);
            vecs[i].mask     = 8'($urandom) & 8'($urandom);
            vecs[i].del      = ($urandom_range(0, 3) == 0);
            vecs[i].exp_bwe  = model_bwe(vecs[i].addr);
            vecs[i].exp_wbit = model_wbits(vecs[i].data, vecs[i].mask, vecs[i].del);
        end

        // Async reset before any clock edge.
        #1 rst = 1'b1;
        #1 chk_reset_outputs("reset_async_noclk");
        @(negedge clk);
        rst = 1'b0;

        // Reset pulse mid-idle.
        @(negedge clk);
        #1 rst = 1'b1;
        #1 chk_reset_outputs("reset_idle");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) issue(vecs[i]);

        // Back-to-back: valid stays high, fields scrambled mid-sweep.
        begin
            vec_t b;
            b.addr     = 4'd9;
            b.data     = 8'h3E;
            b.mask     = 8'h81;
            b.del      = 1'b0;
            b.exp_bwe  = model_bwe(b.addr);
            b.exp_wbit = model_wbits(b.data, b.mask, b.del);
            wait_ready();
            req_addr  = vecs[0].addr;
            req_data  = vecs[0].data;
            req_mask  = vecs[0].mask;
            req_del   = vecs[0].del;
            req_valid = 1'b1;
            @(posedge clk);
            #1;
            sweep(vecs[0].exp_bwe, vecs[0].exp_wbit, 1'b1);
            req_addr = b.addr;
            req_data = b.data;
            req_mask = b.mask;
            req_del  = b.del;
            @(negedge clk);
            chk("b2b_ready_after_done", {62'd0, req_ready, done}, 64'd2);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            sweep(b.exp_bwe, b.exp_wbit, 1'b1);
            @(negedge clk);
            chk("b2b_ready_back", {62'd0, req_ready, done}, 64'd2);
            $display("txn back-to-back addr=%0d then addr=%0d", vecs[0].addr, b.addr);
        end

        // Abort mid-sweep with async reset.
        wait_ready();
        req_addr  = 4'd7;
        req_data  = 8'hFF;
        req_mask  = 8'h00;
        req_del   = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_pre_we", {62'd0, sram_we, req_ready}, 64'd2);
        #1 rst = 1'b1;
        #1 chk_reset_outputs("abort_async");
        @(negedge clk);
        rst = 1'b0;
        $display("txn abort at write cycle 10");
        issue(vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
